iob_iob2axi_wr_stream: RTL and testbench
========================================

Name: iob_iob2axi_wr_stream

Overview:
- Parametrised AXI4 write-burst engine; next generation of the IOb-to-AXI bridge, write direction only.
- Accepts a stream of words on an IOb native slave port into an internal FIFO.
- Writes the words to memory as AXI4 INCR bursts for a programmed start address and total word count.
- Burst size is limited by MAX_BURST, by the words remaining and by 4 KB boundaries; each burst waits for its full data in the FIFO before AW is issued.

Parameters:
ADDR_W  32  byte address width (IOb and AXI)
DATA_W  32  data width, power of 2, >= 8
AXI_LEN_W  8  AXI awlen width
MAX_BURST  16  max beats per burst, 1..2^AXI_LEN_W, <= 2^FIFO_ADDR_W
FIFO_ADDR_W  5  FIFO depth = 2^FIFO_ADDR_W words (data+strobe)
LEN_W  16  width of total transfer length in words

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start transfer (sampled in IDLE only)
addr_i  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored
len_i  in  LEN_W  total words to write
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle completion pulse
error_o  out  1  sticky: some bresp != OKAY
iob_valid_i  in  1  stream word valid
iob_wdata_i  in  DATA_W  stream word
iob_wstrb_i  in  DATA_W/8  byte strobes, passed to wstrb
iob_ready_o  out  1  word accepted when valid & ready
m_axi_awaddr_o  out  ADDR_W  burst address
m_axi_awlen_o  out  AXI_LEN_W  beats-1
m_axi_awsize_o / m_axi_awburst_o  out  3 / 2  constants log2(DATA_W/8) / 2'b01 INCR
m_axi_awvalid_o  out  1
m_axi_awready_i  in  1
m_axi_wdata_o  out  DATA_W
m_axi_wstrb_o  out  DATA_W/8
m_axi_wlast_o  out  1
m_axi_wvalid_o  out  1
m_axi_wready_i  in  1
m_axi_bresp_i  in  2
m_axi_bvalid_i  in  1
m_axi_bready_o  out  1

Behaviour:
- Reset value 0 on every output except the constants awsize/awburst.
- Reset empties the FIFO, clears the counters and error_o, and goes to IDLE. Reset mid-burst abandons the transaction; the AXI slave is reset with it.
- States: IDLE, FILL, AW, W, B, DONE.
- IDLE:
  - start_i with len_i != 0: latch word-aligned addr, rem = len_i, acc = 0, clear error_o, go to FILL. busy_o = 1 from the next cycle.
  - start_i with len_i == 0: go to DONE, no AXI traffic.
  - start_i outside IDLE is ignored.
- iob_ready_o = busy_o & ~fifo_full & (acc != len). Accepted words increment acc. Words beyond len are never accepted. FIFO push and pop in the same cycle are legal.
- Burst length (computed in FILL): blen = min(MAX_BURST, rem, words to next 4 KB boundary). Words to boundary = (4096 - addr[11:0]) / (DATA_W/8).
- FILL -> AW when fifo_level >= blen.
- AW: awvalid = 1, awaddr = addr, awlen = blen-1. All three are held stable until awready; on awready go to W.
- W:
  - wvalid = ~fifo_empty; wdata/wstrb come from the FIFO head.
  - Pop on wvalid & wready.
  - Beat counter starts at 1; wlast = 1 when counter == blen.
  - On the last handshake go to B.
- B:
  - bready = 1.
  - On bvalid: bresp != 2'b00 sets error_o; addr += blen*DATA_W/8; rem -= blen.
  - Then go to DONE if rem == 0, else FILL.
- DONE: done_o = 1 for exactly one cycle, busy_o = 0 in the same cycle, then IDLE.
- W never precedes AW. One outstanding burst at a time.
- error_o holds until the next accepted start_i or reset. The transfer always completes all bursts despite errors.
- Address arithmetic wraps modulo 2^ADDR_W; no error is raised.

Test Plan:
- addr 0x100, len 4, all readies high: one AW (awaddr 0x100, awlen 3, awsize 2) -> 4 W beats, wlast on beat 4 -> done_o one cycle after bvalid.
- addr 0x0, len 40, MAX_BURST 16: bursts at 0x0/0x40/0x80 with awlen 15/15/7 -> 40 words in order, one done_o.
- addr 0xFF8, len 4, DATA_W 32: split at boundary into awaddr 0xFF8 awlen 1, then 0x1000 awlen 1.
- Random valid gaps on iob_valid_i; awready/wready held low up to 10 cycles:
  - wdata sequence equals input sequence, no loss or duplication;
  - awaddr/awlen stable while awvalid waits.
- bresp = SLVERR (2'b10) on second of three bursts -> error_o = 1 from that cycle through done_o; cleared by next start_i.
- len 0 -> done_o the cycle after start_i, awvalid never asserted.
- rst_i during W beat 3 -> all outputs 0 next cycle; FIFO empty (iob_ready_o 0 until a new start).

Source files
------------

// File: rtl/iob_iob2axi_wr_stream.sv
// iob_iob2axi_wr_stream: buffers an IOb word stream (iob_*) in a FIFO and writes it as AXI4 INCR bursts (m_axi_*), split at MAX_BURST and 4 KB, controlled by start_i/addr_i/len_i with busy_o/done_o/error_o status
module iob_iob2axi_wr_stream #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int AXI_LEN_W = 8,
  parameter int MAX_BURST = 16,
  parameter int FIFO_ADDR_W = 5,
  parameter int LEN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  input  logic                 iob_valid_i,
  input  logic [DATA_W-1:0]    iob_wdata_i,
  input  logic [DATA_W/8-1:0]  iob_wstrb_i,
  output logic                 iob_ready_o,
  output logic [ADDR_W-1:0]    m_axi_awaddr_o,
  output logic [AXI_LEN_W-1:0] m_axi_awlen_o,
  output logic [2:0]           m_axi_awsize_o,
  output logic [1:0]           m_axi_awburst_o,
  output logic                 m_axi_awvalid_o,
  input  logic                 m_axi_awready_i,
  output logic [DATA_W-1:0]    m_axi_wdata_o,
  output logic [DATA_W/8-1:0]  m_axi_wstrb_o,
  output logic                 m_axi_wlast_o,
  output logic                 m_axi_wvalid_o,
  input  logic                 m_axi_wready_i,
  input  logic [1:0]           m_axi_bresp_i,
  input  logic                 m_axi_bvalid_i,
  output logic                 m_axi_bready_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF = $clog2(STRB_W);
  localparam int BL_W = AXI_LEN_W + 1;
  localparam int PW = FIFO_ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] rem, acc, len;
  logic [BL_W-1:0] blen, beat;
  logic error;
  logic [STRB_W+DATA_W-1:0] mem [2**FIFO_ADDR_W];
  logic [PW-1:0] wptr, rptr, level;
  logic push, pop, full, empty;
  logic [31:0] to_bound, blen_m, blen_c;
  assign to_bound = (32'd4096 - 32'(addr[11:0])) >> OFF;
  assign blen_m = 32'(rem) < 32'(MAX_BURST) ? 32'(rem) : 32'(MAX_BURST);
  assign blen_c = to_bound < blen_m ? to_bound : blen_m;
  assign level = wptr - rptr;
  assign full = level[FIFO_ADDR_W];
  assign empty = wptr == rptr;
  assign busy_o = state inside {FILL, AW, W, B};
  assign done_o = state == DONE;
  assign error_o = error;
  assign iob_ready_o = busy_o & ~full & (acc != len);
  assign push = iob_valid_i & iob_ready_o;
  assign m_axi_awvalid_o = state == AW;
  assign m_axi_awaddr_o = m_axi_awvalid_o ? addr : '0;
  assign m_axi_awlen_o = m_axi_awvalid_o ? AXI_LEN_W'(blen - BL_W'(1)) : '0;
  assign m_axi_awsize_o = 3'(OFF);
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_wvalid_o = (state == W) & ~empty;
  assign {m_axi_wstrb_o, m_axi_wdata_o} = m_axi_wvalid_o ? mem[rptr[FIFO_ADDR_W-1:0]] : '0;
  assign m_axi_wlast_o = m_axi_wvalid_o & (beat == blen);
  assign pop = m_axi_wvalid_o & m_axi_wready_i;
  assign m_axi_bready_o = state == B;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start_i ? (len_i != '0 ? FILL : DONE) : IDLE;
      FILL: state_n = 32'(level) >= blen_c ? AW : FILL;
      AW: state_n = m_axi_awready_i ? W : AW;
      W: state_n = pop & m_axi_wlast_o ? B : W;
      B: state_n = m_axi_bvalid_i ? (rem == LEN_W'(blen) ? DONE : FILL) : B;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_ff @(posedge clk_i) if (push) mem[wptr[FIFO_ADDR_W-1:0]] <= {iob_wstrb_i, iob_wdata_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr <= '0;
      rem <= '0;
      acc <= '0;
      len <= '0;
      blen <= '0;
      beat <= '0;
      error <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      acc <= acc + LEN_W'(push);
      beat <= state == AW ? BL_W'(1) : beat + BL_W'(pop);
      if (state == IDLE && start_i) begin
        addr <= addr_i & ~ADDR_W'(STRB_W - 1);
        rem <= len_i;
        len <= len_i;
        acc <= '0;
        error <= 1'b0;
      end
      if (state == FILL) blen <= BL_W'(blen_c);
      if (state == B && m_axi_bvalid_i) begin
        error <= error | (m_axi_bresp_i != 2'b00);
        addr <= addr + (ADDR_W'(blen) << OFF);
        rem <= rem - LEN_W'(blen);
      end
    end
  end
endmodule

// File: tb/tb_iob_iob2axi_wr_stream.sv
// tb_iob_iob2axi_wr_stream: scoreboard bench with an AXI write slave model for iob_iob2axi_wr_stream
module tb_iob_iob2axi_wr_stream;
  logic clk, rst_i, start_i;
  logic [31:0] addr_i;
  logic [15:0] len_i;
  logic busy_o, done_o, error_o;
  logic iob_valid_i, iob_ready_o;
  logic [31:0] iob_wdata_i;
  logic [3:0] iob_wstrb_i;
  logic [31:0] m_axi_awaddr_o;
  logic [7:0] m_axi_awlen_o;
  logic [2:0] m_axi_awsize_o;
  logic [1:0] m_axi_awburst_o;
  logic m_axi_awvalid_o, m_axi_awready_i;
  logic [31:0] m_axi_wdata_o;
  logic [3:0] m_axi_wstrb_o;
  logic m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i;
  logic [1:0] m_axi_bresp_i;
  logic m_axi_bvalid_i, m_axi_bready_o;
  logic [88:0] outs;
  localparam logic [88:0] RST_OUTS = {4'b0, 32'b0, 8'b0, 3'd2, 2'b01, 1'b0, 32'b0, 4'b0, 3'b0};
  int vectors = 0, miscompares = 0;
  logic [39:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [39:0] h, e;
  logic [35:0] ew;
  bit stall = 0, aw_open = 0, hold = 0, aw_seen = 0, exp_err = 0, start_q = 0;
  int pend = 0, beat = 0, cur_len = 0, wbeats = 0, b_idx = 0, err_idx = -1;
  int cyc = 0, b_cyc = 0, done_cyc = 0, done_cnt = 0;

  iob_iob2axi_wr_stream dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .iob_valid_i(iob_valid_i), .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o),
    .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o), .m_axi_awsize_o(m_axi_awsize_o),
    .m_axi_awburst_o(m_axi_awburst_o), .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
    .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wlast_o(m_axi_wlast_o),
    .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
    .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o)
  );

  assign outs = {busy_o, done_o, error_o, iob_ready_o, m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o,
                 m_axi_awburst_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o,
                 m_axi_wvalid_o, m_axi_bready_o};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    cyc++;
    m_axi_awready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_bvalid_i = pend > 0 && (!stall || $urandom_range(0, 1) == 1);
    m_axi_bresp_i = b_idx == err_idx ? 2'b10 : 2'b00;
    #1;
    if (rst_i) begin
      pend = 0; aw_open = 0; hold = 0; exp_err = 0; start_q = 0;
    end else begin
      if (start_q) exp_err = 0;
      start_q = start_i && !busy_o && !done_o;
      vectors++;
      if (error_o !== exp_err) begin
        miscompares++; $display("FAIL error_o: got %b want %b (cycle %0d)", error_o, exp_err, cyc);
      end
      if (m_axi_awvalid_o) aw_seen = 1;
      if (hold) begin
        vectors++;
        if ({m_axi_awaddr_o, m_axi_awlen_o} !== h) begin
          miscompares++; $display("FAIL aw_stable: got %h want %h", {m_axi_awaddr_o, m_axi_awlen_o}, h);
        end
      end
      if (m_axi_wvalid_o) begin
        vectors++;
        if (!aw_open) begin miscompares++; $display("FAIL w_before_aw: wvalid with no open burst"); end
      end
      if (m_axi_awvalid_o && m_axi_awready_i) begin
        vectors++;
        if (exp_aw.size() == 0) begin
          miscompares++; $display("FAIL aw_extra: got %h want none", {m_axi_awaddr_o, m_axi_awlen_o});
        end else begin
          e = exp_aw.pop_front();
          if ({m_axi_awaddr_o, m_axi_awlen_o} !== e) begin
            miscompares++; $display("FAIL aw: got addr %h len %0d want addr %h len %0d",
                                    m_axi_awaddr_o, m_axi_awlen_o, e[39:8], e[7:0]);
          end
        end
        vectors++;
        if (m_axi_awsize_o !== 3'd2 || m_axi_awburst_o !== 2'b01) begin
          miscompares++; $display("FAIL aw_const: got size %0d burst %b want 2 01", m_axi_awsize_o, m_axi_awburst_o);
        end
        aw_open = 1; beat = 0; cur_len = int'(m_axi_awlen_o);
      end
      hold = m_axi_awvalid_o && !m_axi_awready_i;
      h = {m_axi_awaddr_o, m_axi_awlen_o};
      if (m_axi_wvalid_o && m_axi_wready_i) begin
        beat++; wbeats++;
        vectors++;
        if (exp_w.size() == 0) begin
          miscompares++; $display("FAIL w_extra: got %h want none", {m_axi_wstrb_o, m_axi_wdata_o});
        end else begin
          ew = exp_w.pop_front();
          if ({m_axi_wstrb_o, m_axi_wdata_o} !== ew) begin
            miscompares++; $display("FAIL wdata: got %h want %h", {m_axi_wstrb_o, m_axi_wdata_o}, ew);
          end
        end
        vectors++;
        if (m_axi_wlast_o !== (beat == cur_len + 1)) begin
          miscompares++; $display("FAIL wlast: got %b want %b at beat %0d", m_axi_wlast_o, beat == cur_len + 1, beat);
        end
        if (m_axi_wlast_o) begin aw_open = 0; pend++; end
      end
      if (m_axi_bvalid_i && m_axi_bready_o) begin
        if (m_axi_bresp_i != 2'b00) exp_err = 1;
        pend--; b_idx++; b_cyc = cyc;
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d = $urandom;
      logic [3:0] s = 4'($urandom);
      bit got = 0;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(negedge clk); iob_valid_i = 0; end
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        iob_valid_i = 1; iob_wdata_i = d; iob_wstrb_i = s;
        #1 got = iob_ready_o;
      end
      if (got) exp_w.push_back({s, d});
      else begin vectors++; miscompares++; $display("FAIL feed: word %0d not accepted, got ready 0 want 1", i); end
    end
    @(negedge clk) iob_valid_i = 0;
  endtask

  task automatic xfer(input logic [31:0] a, input int n, input bit gaps);
    int d0 = done_cnt;
    bit ok = 0;
    @(negedge clk); addr_i = a; len_i = 16'(n); start_i = 1;
    @(negedge clk); start_i = 0;
    fork
      feed(n, gaps);
      for (int t = 0; t < 5000 && !ok; t++) begin @(negedge clk); #2 ok = done_cnt != d0; end
    join
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL xfer_done: got no done_o want done_o"); end
    repeat (4) @(negedge clk);
    #2;
    vectors++;
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
    vectors++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      miscompares++; $display("FAIL leftover: got aw %0d w %0d want 0 0", exp_aw.size(), exp_w.size());
    end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (outs !== RST_OUTS) begin miscompares++; $display("FAIL reset_outs: got %h want %h", outs, RST_OUTS); end
    rst_i = 0;
    @(negedge clk);
    #2;
    vectors++;
    if (outs !== RST_OUTS) begin miscompares++; $display("FAIL idle_outs: got %h want %h", outs, RST_OUTS); end
  endtask

  task automatic test_single;
    exp_aw.push_back({32'h100, 8'd3});
    xfer(32'h100, 4, 0);
    vectors++;
    if (done_cyc - b_cyc != 1) begin
      miscompares++; $display("FAIL done_latency: got %0d want 1", done_cyc - b_cyc);
    end
  endtask

  task automatic test_multi;
    exp_aw.push_back({32'h0, 8'd15});
    exp_aw.push_back({32'h40, 8'd15});
    exp_aw.push_back({32'h80, 8'd7});
    xfer(32'h0, 40, 0);
  endtask

  task automatic test_boundary;
    exp_aw.push_back({32'hFF8, 8'd1});
    exp_aw.push_back({32'h1000, 8'd1});
    xfer(32'hFF8, 4, 0);
  endtask

  task automatic test_stall;
    stall = 1;
    exp_aw.push_back({32'hFC0, 8'd15});
    exp_aw.push_back({32'h1000, 8'd15});
    exp_aw.push_back({32'h1040, 8'd4});
    xfer(32'hFC3, 37, 1);
    stall = 0;
  endtask

  task automatic test_error;
    b_idx = 0; err_idx = 1;
    exp_aw.push_back({32'h2000, 8'd15});
    exp_aw.push_back({32'h2040, 8'd15});
    exp_aw.push_back({32'h2080, 8'd15});
    xfer(32'h2000, 48, 0);
    err_idx = -1;
    vectors++;
    if (error_o !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got %b want 1", error_o); end
    exp_aw.push_back({32'h3000, 8'd3});
    xfer(32'h3000, 4, 0);
    vectors++;
    if (error_o !== 1'b0) begin miscompares++; $display("FAIL error_clear: got %b want 0", error_o); end
  endtask

  task automatic test_len0;
    aw_seen = 0;
    @(negedge clk); addr_i = 32'h500; len_i = 16'd0; start_i = 1;
    @(negedge clk); start_i = 0;
    #2;
    vectors++;
    if ({done_o, busy_o} !== 2'b10) begin miscompares++; $display("FAIL len0_done: got done %b busy %b want 1 0", done_o, busy_o); end
    @(negedge clk);
    #2;
    vectors++;
    if (done_o !== 1'b0) begin miscompares++; $display("FAIL len0_pulse: got %b want 0", done_o); end
    repeat (3) @(negedge clk);
    vectors++;
    if (aw_seen) begin miscompares++; $display("FAIL len0_aw: got awvalid 1 want 0"); end
  endtask

  task automatic test_reset_mid;
    bit hit = 0;
    exp_aw.push_back({32'h0, 8'd7});
    wbeats = 0;
    @(negedge clk); addr_i = 32'h0; len_i = 16'd8; start_i = 1;
    @(negedge clk); start_i = 0;
    feed(8, 0);
    for (int t = 0; t < 200 && !hit; t++) begin @(negedge clk); #2 hit = wbeats == 2 && m_axi_wvalid_o; end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL beat3_wait: got %0d beats want 2 before beat 3", wbeats); end
    rst_i = 1;
    @(negedge clk);
    #2;
    vectors++;
    if (outs !== RST_OUTS) begin miscompares++; $display("FAIL midreset_outs: got %h want %h", outs, RST_OUTS); end
    rst_i = 0;
    exp_aw.delete(); exp_w.delete();
    iob_valid_i = 1;
    @(negedge clk);
    #2;
    vectors++;
    if ({iob_ready_o, busy_o} !== 2'b00) begin
      miscompares++; $display("FAIL midreset_ready: got ready %b busy %b want 0 0", iob_ready_o, busy_o);
    end
    iob_valid_i = 0;
    exp_aw.push_back({32'h400, 8'd3});
    xfer(32'h400, 4, 0);
  endtask

  initial begin
    rst_i = 1; start_i = 0; addr_i = '0; len_i = '0;
    iob_valid_i = 0; iob_wdata_i = '0; iob_wstrb_i = '0;
    m_axi_awready_i = 0; m_axi_wready_i = 0; m_axi_bvalid_i = 0; m_axi_bresp_i = 0;
    test_reset;
    test_single;
    test_multi;
    test_boundary;
    test_stall;
    test_error;
    test_len0;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
